replay_serializer: RTL and testbench

Downstream consumer of the pattern replay stage. Accepts the 4-bit words on the replay bus, each marked by a one-cycle valid strobe, and buffers them in a small FIFO. Re-serializes each word onto a single-bit valid/ready output stream and counts words that equal a match pattern. This turns the replayed parallel capture back into a serial stream for the next stage.

---
 rtl/replay_serializer.sv | 122 ++++++++++++
 tb/tb_replay_serializer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/replay_serializer.sv
// Buffers replay-bus words in a small FIFO and re-serializes them onto a 1-bit valid/ready stream.
// Counts popped words equal to MATCH_WORD; overflow is sticky when a push is dropped.
module replay_serializer #(
  parameter int              WIDTH      = 4,
  parameter int              DEPTH      = 4,
  parameter bit              MSB_FIRST  = 1'b1,
  parameter logic [WIDTH-1:0] MATCH_WORD = 4'b1010
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         word_in,
  input  logic                     word_valid,
  input  logic                     clr_ovf,
  input  logic                     out_ready,
  output logic                     serial_out,
  output logic                     serial_valid,
  output logic                     word_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               match_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic {EMPTY, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0]   shreg, word_nxt;
  logic [IW-1:0]      idx, idx_nxt, bit_pos;
  logic               pop, push, drop, consume;
  logic               sv_nxt, so_nxt, wl_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    idx_nxt   = idx;
    word_nxt  = shreg;
    consume   = (state == SHIFT) && out_ready;
    case (state)
      EMPTY: begin
        if (fifo_count != '0) begin
          pop       = 1'b1;
          state_nxt = SHIFT;
          idx_nxt   = '0;
          word_nxt  = mem[rd_ptr];
        end
      end
      SHIFT: begin
        if (consume) begin
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
            // Reload in the same edge so consecutive words leave no bubble
            if (fifo_count != '0) begin
              pop      = 1'b1;
              word_nxt = mem[rd_ptr];
            end else begin
              state_nxt = EMPTY;
            end
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase

    push    = word_valid && ((fifo_count < CW'(DEPTH)) || pop);
    drop    = word_valid && !push;
    sv_nxt  = (state_nxt == SHIFT);
    bit_pos = MSB_FIRST ? (LAST_IDX - idx_nxt) : idx_nxt;
    so_nxt  = sv_nxt && word_nxt[bit_pos];
    wl_nxt  = sv_nxt && (idx_nxt == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      shreg        <= '0;
      idx          <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      word_last    <= 1'b0;
      overflow     <= 1'b0;
      match_cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      shreg        <= word_nxt;
      idx          <= idx_nxt;
      serial_out   <= so_nxt;
      serial_valid <= sv_nxt;
      word_last    <= wl_nxt;
      // A drop in the same cycle as a clear keeps the flag set
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (pop && (mem[rd_ptr] == MATCH_WORD) && (match_cnt != 8'hFF))
        match_cnt <= match_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_replay_serializer.sv
// Directed bench for replay_serializer: latency, bit order, backpressure, overflow, full+pop, reset.
module tb_replay_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] word_in = '0;
  logic       word_valid = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       out_ready = 1'b0;
  logic       serial_out, serial_valid, word_last, overflow;
  logic [2:0] fifo_count;
  logic [7:0] match_cnt;

  int checks = 0;
  int failures = 0;

  // consumed-bit history, recorded away from the active edge
  logic [63:0] mon_bits = '0;
  logic [63:0] mon_lasts = '0;
  int mon_n = 0;
  int mon_gaps = 0;
  int cyc = 0;
  int prev_cyc = -10;

  replay_serializer dut (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .clr_ovf(clr_ovf), .out_ready(out_ready), .serial_out(serial_out),
    .serial_valid(serial_valid), .word_last(word_last), .fifo_count(fifo_count),
    .overflow(overflow), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst && serial_valid && out_ready) begin
      mon_bits  = {mon_bits[62:0], serial_out};
      mon_lasts = {mon_lasts[62:0], word_last};
      mon_n     = mon_n + 1;
      if (cyc != prev_cyc + 1) mon_gaps = mon_gaps + 1;
      prev_cyc  = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] w);
    word_in    = w;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    word_valid = 1'b0;
    clr_ovf = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // wait until n bits consumed since base, then compare bit stream and bubble count
  task automatic drain(input string tag, input int base, input int gbase, input int n,
                       input logic [63:0] exp_bits, input int exp_gaps);
    logic [63:0] mask;
    logic [63:0] exp_last;
    int budget;
    budget = 0;
    out_ready = 1'b1;
    while ((mon_n - base) < n && budget < 300) begin
      step();
      budget = budget + 1;
    end
    step();
    mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    exp_last = '0;
    for (int i = 0; i < n; i += 4) exp_last[i] = 1'b1;
    check({tag, "_nbits"}, mon_n - base, n);
    check({tag, "_bits"}, mon_bits & mask, exp_bits);
    check({tag, "_lasts"}, mon_lasts & mask, exp_last);
    check({tag, "_gaps"}, mon_gaps - gbase, exp_gaps);
    check({tag, "_idle"}, serial_valid, 1'b0);
    check({tag, "_cnt0"}, fifo_count, 0);
  endtask

  initial begin
    int base, gbase;

    // reset state
    do_reset();
    check("rst_so", serial_out, 0);
    check("rst_sv", serial_valid, 0);
    check("rst_wl", word_last, 0);
    check("rst_cnt", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_match", match_cnt, 0);

    // single word, latency and bit order
    out_ready = 1'b1;
    push(4'b1010);
    check("lat_sv0", serial_valid, 0);
    check("lat_cnt1", fifo_count, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("single_sv", serial_valid, 1);
      check("single_bit", serial_out, (i == 0 || i == 2) ? 1 : 0);
      check("single_last", word_last, (i == 3) ? 1 : 0);
    end
    step();
    check("single_after_sv", serial_valid, 0);
    check("single_match", match_cnt, 1);

    // back-to-back burst, no bubble
    do_reset();
    base = mon_n; gbase = mon_gaps;
    out_ready = 1'b1;
    push(4'b1010); push(4'b0101); push(4'b1101); push(4'b0011);
    drain("burst", base, gbase, 16, 64'hA5D3, 1);
    check("burst_match", match_cnt, 1);
    check("burst_ovf", overflow, 0);

    // backpressure mid-word
    do_reset();
    base = mon_n; gbase = mon_gaps;
    out_ready = 1'b1;
    push(4'b1011);
    step();
    check("bp_bit0", serial_out, 1);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_sv", serial_valid, 1);
      check("bp_hold_bit", serial_out, 0);
      check("bp_hold_last", word_last, 0);
    end
    drain("bp", base, gbase, 4, 64'hB, 2);

    // overflow, same-cycle set-vs-clear, clear, drain
    do_reset();
    base = mon_n; gbase = mon_gaps;
    push(4'b0001); push(4'b0010); push(4'b0100); push(4'b1000); push(4'b1111);
    check("ovf_cnt4", fifo_count, 4);
    check("ovf_sv", serial_valid, 1);
    check("ovf_not_yet", overflow, 0);
    push(4'b0110);
    check("ovf_set", overflow, 1);
    check("ovf_cnt_hold", fifo_count, 4);
    clr_ovf = 1'b1;
    push(4'b0111);
    check("ovf_set_wins", overflow, 1);
    step();
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    drain("ovf", base, gbase, 20, 64'h1248F, 1);
    check("ovf_match", match_cnt, 0);

    // full FIFO with push on the final-bit consume
    do_reset();
    base = mon_n; gbase = mon_gaps;
    push(4'b0001); push(4'b0010); push(4'b0100); push(4'b1000); push(4'b1111);
    out_ready = 1'b1;
    step(); step(); step();
    check("fp_last_bit", word_last, 1);
    push(4'b1010);
    check("fp_cnt", fifo_count, 4);
    check("fp_ovf", overflow, 0);
    check("fp_sv", serial_valid, 1);
    drain("fp", base, gbase, 24, 64'h1248FA, 1);
    check("fp_match", match_cnt, 1);

    // reset during bit 2 with two words queued
    do_reset();
    out_ready = 1'b1;
    push(4'b1010); push(4'b0110); push(4'b1100);
    step();
    check("mr_cnt2", fifo_count, 2);
    check("mr_last_pre", word_last, 0);
    check("mr_bit2", serial_out, 1);
    rst = 1'b1;
    step();
    check("mr_so", serial_out, 0);
    check("mr_sv", serial_valid, 0);
    check("mr_wl", word_last, 0);
    check("mr_cnt", fifo_count, 0);
    check("mr_match", match_cnt, 0);
    rst = 1'b0;
    base = mon_n; gbase = mon_gaps;
    push(4'b1010);
    drain("mr_after", base, gbase, 4, 64'hA, 1);
    check("mr_after_match", match_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
